// File: rtl/dmem_pkg.sv
// Shared encodings and the captured-request record for the data-memory load/store unit.
package dmem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: load extraction/extension, store merge and size/alignment faults.
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [1:0]  lane,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] wword,
   output logic        fault
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      ldata = rword;
      wword = rword;
      fault = 1'b0;
      b     = rword[{lane, 3'b000} +: 8];
      h     = lane[1] ? rword[31:16] : rword[15:0];
      case (size)
         SIZE_B: begin
            ldata = {{24{sgn & b[7]}}, b};
            wword[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SIZE_H: begin
            ldata = {{16{sgn & h[15]}}, h};
            if (lane[1]) wword[31:16] = wdata[15:0];
            else         wword[15:0]  = wdata[15:0];
            fault = lane[0];
         end
         SIZE_W: begin
            wword = wdata;
            fault = (lane != 2'b00);
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Single-port data memory with a 3-state load/store handshake unit.
// Optional DMEM_RANGE_CHECK_EN: fault addresses beyond the array instead of wrapping.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   logic [1:0]       state;
   dmem_req_t        req_q;
   logic [31:0]      mem [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [31:0]      ld_data;
   logic [31:0]      st_word;
   logic             misalign;
   logic             range_fault;
   logic             fault;

   assign idx       = req_q.addr[IDX_W+1:2];
   assign req_ready = (state == ST_IDLE);
   assign fault     = misalign | range_fault;

`ifdef DMEM_RANGE_CHECK_EN
   assign range_fault = |(req_q.addr >> (IDX_W + 2));
`else
   // Upper address bits are deliberately ignored so accesses wrap.
   logic unused_addr_hi;
   assign unused_addr_hi = |req_q.addr[31:IDX_W+2];
   assign range_fault    = 1'b0;
`endif

   dmem_align u_align (
      .size  (req_q.size),
      .sgn   (req_q.sgn),
      .lane  (req_q.addr[1:0]),
      .rword (mem[idx]),
      .wdata (req_q.wdata),
      .ldata (ld_data),
      .wword (st_word),
      .fault (misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         req_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               req_q <= '{we: req_we, size: req_size, sgn: req_signed,
                          addr: req_addr, wdata: req_wdata};
               state <= ST_ACCESS;
            end
            ST_ACCESS: state <= ST_RESP;
            ST_RESP:   if (rsp_ready) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_rdata <= '0;
      end else if (state == ST_ACCESS) begin
         rsp_valid <= 1'b1;
         rsp_fault <= fault;
         rsp_rdata <= (fault || req_q.we) ? 32'd0 : ld_data;
      end else if (state == ST_RESP && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // Reset clears the whole array, so it lives in registers rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else if (state == ST_ACCESS && req_q.we && !fault) begin
         mem[idx] <= st_word;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-array reference model, directed cases then random traffic.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] mmem [0:1023];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         acc_cyc = 0;
   bit         prev_v = 1'b0;
   bit         rand_ready = 1'b0;
   logic [31:0] hold_rd;
   logic        hold_f;

   dmem_lsu #(.DEPTH_WORDS(256)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) if (rand_ready) #1 rsp_ready = 1'($urandom_range(0, 1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Little-endian byte memory; a request touches 1<<size bytes starting at addr mod 1024.
   task automatic model_op(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic f);
      int a, n;
      logic [31:0] v;
      a = int'(addr % 32'd1024);
      n = 1 << size;
      f = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`ifdef DMEM_RANGE_CHECK_EN
      if (addr >= 32'd1024) f = 1'b1;
`endif
      rd = 32'd0;
      if (!f) begin
         if (we) begin
            for (int k = 0; k < n; k++) mmem[a + k] = wdata[8*k +: 8];
         end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(mmem[a + k]) << (8 * k));
            if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) mmem[i] = 8'h00;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit use_exp, input logic [31:0] e_rd, input logic e_f,
                         input bit drain);
      exp_t e;
      logic [31:0] rd;
      logic f;
      int n = 0;
      model_op(we, size, sgn, addr, wdata, rd, f);
      e.rdata = use_exp ? e_rd : rd;
      e.fault = use_exp ? e_f : f;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed 0 at addr %h", addr);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
      // Scramble the request bus so any late sampling shows up as wrong data.
      req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      if (drain) wait_drain();
   endtask

   // Monitor: response rises one edge after the accept edge, then pops on handshake.
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (rsp_valid && !prev_v) chk("rsp_latency", 32'(cyc - acc_cyc), 32'd1);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: rdata %h fault %b with nothing pending", rsp_rdata, rsp_fault);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, mon_e.rdata);
               chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
            end
         end
         prev_v = rsp_valid;
      end
   end

   initial begin
      int n;
      logic [31:0] a;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
      rst = 1'b0;

      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
      do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h5A,       1'b1, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        1'b1, 32'hFFFFFFAD, 1'b0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b1, 32'h5AADBEEF, 1'b0, 1'b1);
      do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234,     1'b1, 32'h0, 1'b1, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b1, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1'b1, 32'h0, 1'b1, 1'b1);
`ifdef DMEM_RANGE_CHECK_EN
      do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
`else
      do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
`endif

      // Back-pressure: response and req_ready must hold while a new request waits.
      rsp_ready = 1'b0;
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 32'h00005AAD, 1'b0, 1'b0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_seen", 32'(rsp_valid), 32'd1);
      hold_rd = rsp_rdata;
      hold_f  = rsp_fault;
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      req_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, hold_rd);
         chk("stall_fault", 32'(rsp_fault), 32'(hold_f));
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);

      // Reset while a store sits in ACCESS: nothing commits, nothing responds.
      @(posedge clk);
      #1;
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h30; req_wdata = 32'h13572468;
      req_valid = 1'b1;
      @(negedge clk);
      chk("pre_reset_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("reset_no_rsp", 32'(rsp_valid), 32'd0);
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);

      // Random traffic against the model, with random response back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 250; i++) begin
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
         do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                1'b0, 32'h0, 1'b0, 1'b1);
      end
      rand_ready = 1'b0;
      repeat (2) @(posedge clk);
      rsp_ready = 1'b1;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
